// File: rtl/scmp_bus_target.sv
// +------------------------------------------------------------------------+
// | scmp_bus_target : SC/MP external-bus memory target, 2**AW byte RAM      |
// | Wait states enabled by SCMP_BUS_TGT_HOLD_EN.  Rev 1.0                   |
// +------------------------------------------------------------------------+
`default_nettype none

module scmp_bus_target #(
   parameter int          AW          = 10,
   parameter logic [3:0]  PAGE        = 4'h0,
   parameter logic [11:0] BASE        = 12'h000,
   parameter int          HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] adr_i,
   input  logic [7:0]  db_i,
   input  logic        nads,
   input  logic        nrds,
   input  logic        nwds,
   output logic [7:0]  db_o,
   output logic        db_oe,
   output logic        nhold,
   output logic        sel,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_WAIT  = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          rflag_q, rflag_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    db_o_q, db_o_d;
   logic          db_oe_q, db_oe_d;
   logic          nhold_q, nhold_d;
   logic          sel_q, sel_d;
   logic          err_q, err_d;
   logic          ram_we;
   logic          win_hit;
   logic          addr_hit;
   logic          read_ok;
   logic          write_ok;
   logic          any_strobe;
   logic          strobe_lost;

   logic [7:0] mem [0:(1<<AW)-1];

   generate
      if (AW >= 12) begin : g_full_window
         assign win_hit = 1'b1;
      end else begin : g_part_window
         assign win_hit = (adr_i[11:AW] == BASE[11:AW]);
      end
   endgenerate

   assign addr_hit    = win_hit && (db_i[3:0] == PAGE);
   assign read_ok     = !nrds && nwds && rflag_q;
   assign write_ok    = !nwds && nrds && !rflag_q;
   assign any_strobe  = !nrds || !nwds;
   assign strobe_lost = rflag_q ? nrds : nwds;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rflag_d = rflag_q;
      cnt_d   = cnt_q;
      db_o_d  = db_o_q;
      db_oe_d = db_oe_q;
      nhold_d = nhold_q;
      sel_d   = sel_q;
      err_d   = 1'b0;
      ram_we  = 1'b0;

      // A new address strobe overrides whatever cycle is in flight.
      if (!nads) begin
         idx_d   = adr_i[AW-1:0];
         rflag_d = db_i[4];
         sel_d   = addr_hit;
         state_d = addr_hit ? S_ARMED : S_IDLE;
         db_oe_d = 1'b0;
         nhold_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
            end
            S_ARMED: begin
               if (read_ok || write_ok) begin
                  cnt_d = HOLD_LOAD;
`ifdef SCMP_BUS_TGT_HOLD_EN
                  state_d = S_WAIT;
                  nhold_d = 1'b0;
`else
                  if (read_ok) begin
                     db_o_d  = mem[idx_q];
                     db_oe_d = 1'b1;
                     state_d = S_READ;
                  end else begin
                     state_d = S_WRITE;
                  end
`endif
               end else if (any_strobe) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_WAIT: begin
               if (strobe_lost) begin
                  state_d = S_IDLE;
                  nhold_d = 1'b1;
                  sel_d   = 1'b0;
               end else if (cnt_q == 4'd0) begin
                  nhold_d = 1'b1;
                  if (rflag_q) begin
                     db_o_d  = mem[idx_q];
                     db_oe_d = 1'b1;
                     state_d = S_READ;
                  end else begin
                     state_d = S_WRITE;
                  end
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            S_READ: begin
               if (nrds) begin
                  db_oe_d = 1'b0;
                  state_d = S_DONE;
               end
            end
            S_WRITE: begin
               ram_we  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               if (nrds && nwds) begin
                  state_d = S_IDLE;
                  sel_d   = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         rflag_q <= 1'b0;
         cnt_q   <= 4'd0;
         db_o_q  <= 8'h00;
         db_oe_q <= 1'b0;
         nhold_q <= 1'b1;
         sel_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rflag_q <= rflag_d;
         cnt_q   <= cnt_d;
         db_o_q  <= db_o_d;
         db_oe_q <= db_oe_d;
         nhold_q <= nhold_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[idx_q] <= db_i;
      end
   end

   assign db_o  = db_o_q;
   assign db_oe = db_oe_q;
   assign nhold = nhold_q;
   assign sel   = sel_q;
   assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_scmp_bus_target.sv
// +------------------------------------------------------------------------+
// | tb_scmp_bus_target : directed bench for scmp_bus_target. Rev 1.0       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_scmp_bus_target;

`ifdef SCMP_BUS_TGT_HOLD_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic [11:0] adr_i;
   logic [7:0]  db_i;
   logic        nads;
   logic        nrds;
   logic        nwds;
   logic [7:0]  db_o;
   logic        db_oe;
   logic        nhold;
   logic        sel;
   logic        err;

   int vectors;
   int miscompares;

   scmp_bus_target #(
      .AW          (10),
      .PAGE        (4'h0),
      .BASE        (12'h000),
      .HOLD_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .adr_i (adr_i),
      .db_i  (db_i),
      .nads  (nads),
      .nrds  (nrds),
      .nwds  (nwds),
      .db_o  (db_o),
      .db_oe (db_oe),
      .nhold (nhold),
      .sel   (sel),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic addr_phase(input logic [11:0] a, input logic [7:0] st,
                             input logic exp_sel, input string tag);
      nads  = 1'b0;
      adr_i = a;
      db_i  = st;
      step();
      nads  = 1'b1;
      adr_i = 12'h000;
      db_i  = 8'h00;
      chk(tag, {7'd0, sel}, {7'd0, exp_sel});
   endtask

   task automatic write_data(input logic [7:0] d, input string tag);
      nwds = 1'b0;
      db_i = d;
      step();
      for (int i = 0; i < L; i++) begin
         chk({tag, "_nhold_lo"}, {7'd0, nhold}, 8'h00);
         step();
      end
      chk({tag, "_nhold_hi"}, {7'd0, nhold}, 8'h01);
      step();
      nwds = 1'b1;
      db_i = 8'h00;
      step();
      chk({tag, "_sel_clr"}, {7'd0, sel}, 8'h00);
   endtask

   task automatic read_data(input logic [7:0] exp, input string tag);
      nrds = 1'b0;
      step();
      for (int i = 0; i < L; i++) begin
         chk({tag, "_nhold_lo"}, {7'd0, nhold}, 8'h00);
         chk({tag, "_oe_early"}, {7'd0, db_oe}, 8'h00);
         step();
      end
      chk({tag, "_oe"}, {7'd0, db_oe}, 8'h01);
      chk({tag, "_data"}, db_o, exp);
      chk({tag, "_nhold_hi"}, {7'd0, nhold}, 8'h01);
      step();
      chk({tag, "_oe_held"}, {7'd0, db_oe}, 8'h01);
      nrds = 1'b1;
      step();
      chk({tag, "_oe_off"}, {7'd0, db_oe}, 8'h00);
      step();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b1;
      adr_i = 12'h000;
      db_i  = 8'h00;
      nads  = 1'b1;
      nrds  = 1'b1;
      nwds  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_db_o", db_o, 8'h00);
      chk("rst_db_oe", {7'd0, db_oe}, 8'h00);
      chk("rst_nhold", {7'd0, nhold}, 8'h01);
      chk("rst_sel", {7'd0, sel}, 8'h00);
      chk("rst_err", {7'd0, err}, 8'h00);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Write 0x5A to 0x0012, read it back
      addr_phase(12'h012, 8'h00, 1'b1, "wr012_sel");
      write_data(8'h5A, "wr012");
      addr_phase(12'h012, 8'h10, 1'b1, "rd012_sel");
      read_data(8'h5A, "rd012");

      // Reset asserted while read data is being driven
      addr_phase(12'h012, 8'h10, 1'b1, "rstmid_sel");
      nrds = 1'b0;
      step();
      for (int i = 0; i < L; i++) step();
      chk("rstmid_pre_oe", {7'd0, db_oe}, 8'h01);
      rst_n = 1'b0;
      #1;
      chk("rstmid_oe", {7'd0, db_oe}, 8'h00);
      chk("rstmid_nhold", {7'd0, nhold}, 8'h01);
      chk("rstmid_sel", {7'd0, sel}, 8'h00);
      nrds = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Page mismatch read, then page mismatch write
      addr_phase(12'h012, 8'h11, 1'b0, "pg_rd_sel");
      nrds = 1'b0;
      for (int i = 0; i < L + 2; i++) begin
         step();
         chk("pg_rd_oe", {7'd0, db_oe}, 8'h00);
         chk("pg_rd_nhold", {7'd0, nhold}, 8'h01);
         chk("pg_rd_sel_hold", {7'd0, sel}, 8'h00);
      end
      nrds = 1'b1;
      step();
      addr_phase(12'h012, 8'h01, 1'b0, "pg_wr_sel");
      nwds = 1'b0;
      db_i = 8'hAA;
      step();
      step();
      step();
      nwds = 1'b1;
      db_i = 8'h00;
      step();
      addr_phase(12'h412, 8'h10, 1'b0, "win_sel");
      step();
      addr_phase(12'h012, 8'h10, 1'b1, "pg_chk_sel");
      read_data(8'h5A, "pg_chk");

      // Strobe without address phase
      nrds = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("noads_oe", {7'd0, db_oe}, 8'h00);
         chk("noads_err", {7'd0, err}, 8'h00);
         chk("noads_sel", {7'd0, sel}, 8'h00);
      end
      nrds = 1'b1;
      step();

      // Read-flagged cycle with write strobe
      addr_phase(12'h012, 8'h10, 1'b1, "perr1_sel");
      nwds = 1'b0;
      db_i = 8'hFF;
      step();
      chk("perr1_err", {7'd0, err}, 8'h01);
      step();
      chk("perr1_err_off", {7'd0, err}, 8'h00);
      nwds = 1'b1;
      db_i = 8'h00;
      step();
      chk("perr1_sel_clr", {7'd0, sel}, 8'h00);

      // Both strobes low
      addr_phase(12'h012, 8'h10, 1'b1, "perr2_sel");
      nrds = 1'b0;
      nwds = 1'b0;
      step();
      chk("perr2_err", {7'd0, err}, 8'h01);
      chk("perr2_oe", {7'd0, db_oe}, 8'h00);
      step();
      chk("perr2_err_off", {7'd0, err}, 8'h00);
      nrds = 1'b1;
      nwds = 1'b1;
      step();
      addr_phase(12'h012, 8'h10, 1'b1, "perr_chk_sel");
      read_data(8'h5A, "perr_chk");

      // Abort a write to 0x020 with a new address phase to 0x021
      addr_phase(12'h020, 8'h00, 1'b1, "pre020_sel");
      write_data(8'h33, "pre020");
      addr_phase(12'h020, 8'h00, 1'b1, "ab020_sel");
      nwds = 1'b0;
      db_i = 8'hC3;
      step();
      nwds  = 1'b1;
      nads  = 1'b0;
      adr_i = 12'h021;
      db_i  = 8'h00;
      step();
      nads  = 1'b1;
      adr_i = 12'h000;
      chk("ab_nhold", {7'd0, nhold}, 8'h01);
      chk("ab_sel", {7'd0, sel}, 8'h01);
      write_data(8'h7E, "ab021");
      addr_phase(12'h020, 8'h10, 1'b1, "ab_rd020_sel");
      read_data(8'h33, "ab_rd020");
      addr_phase(12'h021, 8'h10, 1'b1, "ab_rd021_sel");
      read_data(8'h7E, "ab_rd021");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
